// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX bundle: decoded instruction in, registered EX copy and hazard out.
// The ID side (master) drives id_*, stall and flush; the register (slave) drives ex_*.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 9,
  parameter int CNT_W      = 16
);
  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [DATA_W-1:0]     id_pc4;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [DATA_W-1:0]     id_imm_ext;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rt;
  logic [CTRL_W-1:0]     id_ctrl;
  logic                  hazard_stall;
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_pc4;
  logic [DATA_W-1:0]     ex_rs_data;
  logic [DATA_W-1:0]     ex_rt_data;
  logic [DATA_W-1:0]     ex_imm_ext;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_pc4,
           id_rs_data, id_rt_data, id_imm_ext,
           id_rs, id_rt, id_rd, id_uses_rt, id_ctrl,
    input  hazard_stall, ex_valid, ex_pc4,
           ex_rs_data, ex_rt_data, ex_imm_ext,
           ex_rs, ex_rt, ex_rd, ex_ctrl, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_pc4,
           id_rs_data, id_rt_data, id_imm_ext,
           id_rs, id_rt, id_rd, id_uses_rt, id_ctrl,
    output hazard_stall, ex_valid, ex_pc4,
           ex_rs_data, ex_rt_data, ex_imm_ext,
           ex_rs, ex_rt, ex_rd, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use bubble insertion,
// external hold, branch squash and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 9,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_pipe_reg_if.slave  bus
);
  localparam int MEM_RD = 7;

  logic                  v_q;
  logic [DATA_W-1:0]     pc4_q;
  logic [DATA_W-1:0]     rsd_q;
  logic [DATA_W-1:0]     rtd_q;
  logic [DATA_W-1:0]     imm_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  hz;
  logic                  rt_hit;

  // $0 is never a real load target, so it cannot create a dependency
  assign rt_hit = (rt_q == bus.id_rs)
                | (bus.id_uses_rt & (rt_q == bus.id_rt));

  assign hz = bus.id_valid & v_q & ctrl_q[MEM_RD]
            & (rt_q != '0) & rt_hit;

  assign bus.hazard_stall = hz & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      pc4_q  <= '0;
      rsd_q  <= '0;
      rtd_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else if (bus.flush || (!bus.stall && hz)) begin
      v_q    <= 1'b0;
      pc4_q  <= '0;
      rsd_q  <= '0;
      rtd_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
      if (!bus.flush && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end else if (!bus.stall) begin
      v_q    <= bus.id_valid;
      pc4_q  <= bus.id_pc4;
      rsd_q  <= bus.id_rs_data;
      rtd_q  <= bus.id_rt_data;
      imm_q  <= bus.id_imm_ext;
      rs_q   <= bus.id_rs;
      rt_q   <= bus.id_rt;
      rd_q   <= bus.id_rd;
      ctrl_q <= bus.id_valid ? bus.id_ctrl : '0;
    end
  end

  assign bus.ex_valid   = v_q;
  assign bus.ex_pc4     = pc4_q;
  assign bus.ex_rs_data = rsd_q;
  assign bus.ex_rt_data = rtd_q;
  assign bus.ex_imm_ext = imm_q;
  assign bus.ex_rs      = rs_q;
  assign bus.ex_rt      = rt_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_ctrl    = ctrl_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg; a second 2-bit-counter
// copy shares the stimulus to exercise counter saturation.
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int errs = 0;
  logic [15:0] exp_bub = '0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if bif ();
  id_ex_pipe_reg_if #(.CNT_W(2)) sif ();

  assign sif.stall      = bif.stall;
  assign sif.flush      = bif.flush;
  assign sif.id_valid   = bif.id_valid;
  assign sif.id_pc4     = bif.id_pc4;
  assign sif.id_rs_data = bif.id_rs_data;
  assign sif.id_rt_data = bif.id_rt_data;
  assign sif.id_imm_ext = bif.id_imm_ext;
  assign sif.id_rs      = bif.id_rs;
  assign sif.id_rt      = bif.id_rt;
  assign sif.id_rd      = bif.id_rd;
  assign sif.id_uses_rt = bif.id_uses_rt;
  assign sif.id_ctrl    = bif.id_ctrl;

  id_ex_pipe_reg u_dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  id_ex_pipe_reg #(.CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sif));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc4,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic urt, input logic [8:0] ctrl);
    bif.id_valid   = v;
    bif.id_pc4     = pc4;
    bif.id_rs_data = rsd;
    bif.id_rt_data = rtd;
    bif.id_imm_ext = imm;
    bif.id_rs      = rs;
    bif.id_rt      = rt;
    bif.id_rd      = rd;
    bif.id_uses_rt = urt;
    bif.id_ctrl    = ctrl;
    #1;
  endtask

  task automatic test_reset();
    bif.stall = 1'b0;
    bif.flush = 1'b0;
    set_id(1, 32'h4, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 1, 9'h1FF);
    #20;
    rst_n = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (bif.ex_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %h want 0", bif.ex_valid); end
    vec++; if (bif.ex_ctrl !== 9'h0) begin errs++; $display("FAIL rst_ctrl got %h want 000", bif.ex_ctrl); end
    vec++; if (bif.ex_imm_ext !== 32'h0) begin errs++; $display("FAIL rst_imm got %h want 0", bif.ex_imm_ext); end
    vec++; if (bif.ex_rt !== 5'd0) begin errs++; $display("FAIL rst_rt got %h want 0", bif.ex_rt); end
    vec++; if (bif.bubble_cnt !== 16'd0) begin errs++; $display("FAIL rst_cnt got %h want 0", bif.bubble_cnt); end
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL rst_hz got %h want 0", bif.hazard_stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    set_id(1, 32'h104, 32'h11, 32'h22, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd3, 1, 9'h1A5);
    step();
    vec++; if (bif.ex_imm_ext !== 32'hFFFF_FFF0) begin errs++; $display("FAIL pass_imm got %h want fffffff0", bif.ex_imm_ext); end
    vec++; if (bif.ex_ctrl !== 9'h1A5) begin errs++; $display("FAIL pass_ctrl got %h want 1a5", bif.ex_ctrl); end
    vec++; if (bif.ex_valid !== 1'b1) begin errs++; $display("FAIL pass_valid got %h want 1", bif.ex_valid); end
    vec++; if (bif.ex_pc4 !== 32'h104) begin errs++; $display("FAIL pass_pc4 got %h want 104", bif.ex_pc4); end
    vec++; if (bif.ex_rt_data !== 32'h22) begin errs++; $display("FAIL pass_rtd got %h want 22", bif.ex_rt_data); end
    vec++; if (bif.ex_rd !== 5'd3) begin errs++; $display("FAIL pass_rd got %h want 3", bif.ex_rd); end
    set_id(0, 32'h108, 32'h0, 32'h0, 32'h0, 5'd2, 5'd2, 5'd0, 1, 9'h1FF);
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL inv_hz got %h want 0", bif.hazard_stall); end
    step();
    vec++; if (bif.ex_valid !== 1'b0) begin errs++; $display("FAIL inv_valid got %h want 0", bif.ex_valid); end
    vec++; if (bif.ex_ctrl !== 9'h0) begin errs++; $display("FAIL inv_ctrl got %h want 000", bif.ex_ctrl); end
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL inv_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
  endtask

  task automatic test_load_use();
    set_id(1, 32'h1FC, 32'h0, 32'h0, 32'h8, 5'd1, 5'd5, 5'd0, 0, 9'h180);
    step();
    set_id(1, 32'h200, 32'hAA, 32'hBB, 32'h0, 5'd5, 5'd6, 5'd7, 1, 9'h104);
    vec++; if (bif.hazard_stall !== 1'b1) begin errs++; $display("FAIL lu_hz got %h want 1", bif.hazard_stall); end
    step();
    exp_bub = exp_bub + 1;
    vec++; if (bif.ex_valid !== 1'b0) begin errs++; $display("FAIL lu_bub_valid got %h want 0", bif.ex_valid); end
    vec++; if (bif.ex_ctrl !== 9'h0) begin errs++; $display("FAIL lu_bub_ctrl got %h want 000", bif.ex_ctrl); end
    vec++; if (bif.ex_rs !== 5'd0) begin errs++; $display("FAIL lu_bub_rs got %h want 0", bif.ex_rs); end
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL lu_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL lu_hz_clr got %h want 0", bif.hazard_stall); end
    step();
    vec++; if (bif.ex_valid !== 1'b1) begin errs++; $display("FAIL lu_ld_valid got %h want 1", bif.ex_valid); end
    vec++; if (bif.ex_ctrl !== 9'h104) begin errs++; $display("FAIL lu_ld_ctrl got %h want 104", bif.ex_ctrl); end
    vec++; if (bif.ex_pc4 !== 32'h200) begin errs++; $display("FAIL lu_ld_pc4 got %h want 200", bif.ex_pc4); end
    set_id(1, 32'h204, 32'h0, 32'h0, 32'h0, 5'd2, 5'd9, 5'd0, 0, 9'h180);
    step();
    set_id(1, 32'h208, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd4, 1, 9'h104);
    vec++; if (bif.hazard_stall !== 1'b1) begin errs++; $display("FAIL lu_rt_hz got %h want 1", bif.hazard_stall); end
    step();
    exp_bub = exp_bub + 1;
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL lu_rt_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
    step();
    vec++; if (bif.ex_rd !== 5'd4) begin errs++; $display("FAIL lu_rt_rd got %h want 4", bif.ex_rd); end
  endtask

  task automatic test_priority();
    set_id(1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd3, 5'd5, 5'd0, 0, 9'h180);
    step();
    set_id(1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1, 5'd2, 0, 9'h100);
    bif.stall = 1'b1;
    #1;
    vec++; if (bif.hazard_stall !== 1'b1) begin errs++; $display("FAIL pr_hz got %h want 1", bif.hazard_stall); end
    step();
    vec++; if (bif.ex_valid !== 1'b1) begin errs++; $display("FAIL pr_hold_valid got %h want 1", bif.ex_valid); end
    vec++; if (bif.ex_ctrl !== 9'h180) begin errs++; $display("FAIL pr_hold_ctrl got %h want 180", bif.ex_ctrl); end
    vec++; if (bif.ex_pc4 !== 32'h300) begin errs++; $display("FAIL pr_hold_pc4 got %h want 300", bif.ex_pc4); end
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL pr_hold_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
    bif.flush = 1'b1;
    #1;
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL pr_fl_hz got %h want 0", bif.hazard_stall); end
    step();
    vec++; if (bif.ex_valid !== 1'b0) begin errs++; $display("FAIL pr_fl_valid got %h want 0", bif.ex_valid); end
    vec++; if (bif.ex_rt !== 5'd0) begin errs++; $display("FAIL pr_fl_rt got %h want 0", bif.ex_rt); end
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL pr_fl_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
    bif.flush = 1'b0;
    bif.stall = 1'b0;
  endtask

  task automatic test_rt_zero();
    set_id(1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0, 0, 9'h180);
    step();
    set_id(1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0, 1, 9'h180);
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL r0_hz got %h want 0", bif.hazard_stall); end
    step();
    vec++; if (bif.ex_rt !== 5'd7) begin errs++; $display("FAIL r0_ld_rt got %h want 7", bif.ex_rt); end
    set_id(1, 32'h408, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7, 5'd1, 0, 9'h100);
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL rt_nouse_hz got %h want 0", bif.hazard_stall); end
    bif.id_uses_rt = 1'b1;
    #1;
    vec++; if (bif.hazard_stall !== 1'b1) begin errs++; $display("FAIL rt_use_hz got %h want 1", bif.hazard_stall); end
    bif.id_valid = 1'b0;
    #1;
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL rt_inv_hz got %h want 0", bif.hazard_stall); end
    step();
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL rt_inv_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 32'h500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0, 0, 9'h180);
      step();
      set_id(1, 32'h504, 32'h0, 32'h0, 32'h0, 5'd5, 5'd2, 5'd3, 0, 9'h100);
      step();
      exp_bub = exp_bub + 1;
      vec++; if (sif.bubble_cnt !== 2'd3) begin errs++; $display("FAIL sat_cnt%0d got %h want 3", i, sif.bubble_cnt); end
    end
    vec++; if (bif.bubble_cnt !== exp_bub) begin errs++; $display("FAIL wide_cnt got %h want %h", bif.bubble_cnt, exp_bub); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd6, 5'd0, 0, 9'h180);
    step();
    set_id(1, 32'h604, 32'h0, 32'h0, 32'h0, 5'd6, 5'd2, 5'd3, 0, 9'h100);
    bif.stall = 1'b1;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    vec++; if (bif.ex_valid !== 1'b0) begin errs++; $display("FAIL mrst_valid got %h want 0", bif.ex_valid); end
    vec++; if (bif.bubble_cnt !== 16'd0) begin errs++; $display("FAIL mrst_cnt got %h want 0", bif.bubble_cnt); end
    vec++; if (bif.hazard_stall !== 1'b0) begin errs++; $display("FAIL mrst_hz got %h want 0", bif.hazard_stall); end
    bif.stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_priority();
    test_rt_zero();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
